// File: rtl/ssp_audio_sampler.sv
// Block-averaging audio decimator for the PSG mix: average, optional DC block, gain/saturate, valid/ready output.
// Optional DC-blocking stage is compiled in only when SSP_AUDIO_DC_BLOCK_EN is defined.
module ssp_audio_sampler #(
  parameter int AVG_LOG2 = 4,
  parameter int DC_SHIFT = 10
) (
  input  logic        clk_logic_i,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic [15:0] audio_i,
  input  logic [3:0]  volume_i,
  output logic [15:0] sample_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        overrun_o
);

  localparam int AW = 16 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic signed [22:0] SAT_MAX = 23'sd32767;
  localparam logic signed [22:0] SAT_MIN = -23'sd32768;

  if (AVG_LOG2 < 0 || AVG_LOG2 > 8 || DC_SHIFT < 4 || DC_SHIFT > 15) begin : g_bad_param
    $error("ssp_audio_sampler: parameter out of legal range");
  end

  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_sum;
  logic [CW-1:0]      cnt;
  logic               block_done;
  logic [15:0]        s1_mean;
  logic               s1_valid;
  logic signed [17:0] x_next;
  logic signed [17:0] s2_x;
  logic               s2_valid;
  logic signed [22:0] prod;
  logic signed [22:0] scaled;
  logic [15:0]        sat;

  // The final sample of a block is folded in via acc_sum so nothing is lost on the wrap.
  assign acc_sum    = acc + AW'(audio_i);
  assign block_done = ce_i && (cnt == CNT_LAST);

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      acc <= '0;
      cnt <= '0;
    end else if (ce_i) begin
      if (cnt == CNT_LAST) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      s1_mean  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= block_done;
      if (block_done) begin
        s1_mean <= 16'(acc_sum >> AVG_LOG2);
      end
    end
  end

`ifdef SSP_AUDIO_DC_BLOCK_EN
  logic signed [16:0] dc;

  assign x_next = $signed({2'b00, s1_mean}) - $signed({dc[16], dc});

  // Leaky integrator tracks the DC level; it only moves when a mean passes through.
  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      dc <= '0;
    end else if (s1_valid) begin
      dc <= dc + 17'(x_next >>> DC_SHIFT);
    end
  end
`else
  assign x_next = $signed({2'b00, s1_mean});
`endif

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      s2_x     <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_x <= x_next;
      end
    end
  end

  assign prod   = 23'(s2_x) * 23'($signed({1'b0, volume_i}));
  assign scaled = prod >>> 3;

  always_comb begin
    sat = scaled[15:0];
    if (scaled > SAT_MAX) begin
      sat = 16'h7FFF;
    end else if (scaled < SAT_MIN) begin
      sat = 16'h8000;
    end
  end

  // A fresh result may replace the held one only when that one is being accepted this cycle.
  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      sample_o  <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (s2_valid) begin
        if (!valid_o || ready_i) begin
          sample_o <= sat;
          valid_o  <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ssp_audio_sampler.sv
// Directed bench for ssp_audio_sampler: table of block vectors plus hand-written handshake/reset sequences.
// Expectations for the DC-block build are selected with SSP_AUDIO_DC_BLOCK_EN.
module tb_ssp_audio_sampler;

  logic        clk_logic_i = 1'b0;
  logic        reset_i;
  logic        ce_i;
  logic [15:0] audio_i;
  logic [3:0]  volume_i;
  logic [15:0] sample_o;
  logic        valid_o;
  logic        ready_i;
  logic        overrun_o;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [15:0] base;
    logic [15:0] step;
    logic [3:0]  vol;
    logic [15:0] expSample;
  } vec_t;

  vec_t        vecs [9];
  logic [15:0] decay [4];
  logic [15:0] blk2Exp;

  ssp_audio_sampler #(.AVG_LOG2(4), .DC_SHIFT(4)) dut (
    .clk_logic_i(clk_logic_i),
    .reset_i    (reset_i),
    .ce_i       (ce_i),
    .audio_i    (audio_i),
    .volume_i   (volume_i),
    .sample_o   (sample_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overrun_o  (overrun_o)
  );

  always #5 clk_logic_i = ~clk_logic_i;

  task automatic tick();
    @(posedge clk_logic_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset_i = 1'b1;
    ce_i    = 1'b0;
    tick();
    reset_i = 1'b0;
    tick();
  endtask

  task automatic pushCe(input logic [15:0] a);
    audio_i = a;
    ce_i    = 1'b1;
    tick();
    ce_i    = 1'b0;
  endtask

  // Sixteen ce pulses every 4 cycles; returns right after the edge that took the last sample.
  task automatic runCes(input logic [15:0] base, input logic [15:0] step, input logic [3:0] vol);
    volume_i = vol;
    for (int i = 0; i < 16; i++) begin
      pushCe(base + 16'(i) * step);
      if (i < 15) idle(3);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] base, input logic [15:0] step, input logic [3:0] vol,
                               output logic earlyValid, output logic latValid, output logic [15:0] latSample);
    runCes(base, step, vol);
    tick();
    earlyValid = valid_o;
    tick();
    latValid  = valid_o;
    latSample = sample_o;
  endtask

  initial begin
    logic        ev;
    logic        lv;
    logic [15:0] ls;
    logic        sawValid;

    vecs[0] = '{16'h0100, 16'h0000, 4'd8,  16'h0100};
    vecs[1] = '{16'hFFFF, 16'h0000, 4'd15, 16'h7FFF};
    vecs[2] = '{16'hFFFF, 16'h0000, 4'd0,  16'h0000};
    vecs[3] = '{16'h1234, 16'h0000, 4'd4,  16'h091A};
    vecs[4] = '{16'h8000, 16'h0000, 4'd8,  16'h7FFF};
    vecs[5] = '{16'h7FFF, 16'h0000, 4'd8,  16'h7FFF};
    vecs[6] = '{16'h0003, 16'h0000, 4'd3,  16'h0001};
    vecs[7] = '{16'h1000, 16'h0002, 4'd8,  16'h100F};
    vecs[8] = '{16'hFFF0, 16'h0001, 4'd1,  16'h1FFE};
`ifdef SSP_AUDIO_DC_BLOCK_EN
    decay   = '{16'h0100, 16'h00F0, 16'h00E1, 16'h00D3};
    blk2Exp = 16'h02F0;
`else
    decay   = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    blk2Exp = 16'h0300;
`endif

    reset_i  = 1'b1;
    ce_i     = 1'b0;
    audio_i  = '0;
    volume_i = 4'd8;
    ready_i  = 1'b1;
    tick();
    checkOutput("reset_sample",  sample_o, 16'h0000);
    checkOutput("reset_valid",   16'(valid_o), 16'h0000);
    checkOutput("reset_overrun", 16'(overrun_o), 16'h0000);
    reset_i = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      doReset();
      ready_i = 1'b1;
      applyStimulus(vecs[v].base, vecs[v].step, vecs[v].vol, ev, lv, ls);
      checkOutput($sformatf("vec%0d_early_valid", v), 16'(ev), 16'h0000);
      checkOutput($sformatf("vec%0d_valid", v), 16'(lv), 16'h0001);
      checkOutput($sformatf("vec%0d_sample", v), ls, vecs[v].expSample);
      idle(2);
    end

    // Back-to-back blocks of a constant level: flat without DC block, decaying with it.
    doReset();
    ready_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      applyStimulus(16'h0100, 16'h0000, 4'd8, ev, lv, ls);
      checkOutput($sformatf("series%0d_valid", b), 16'(lv), 16'h0001);
      checkOutput($sformatf("series%0d_sample", b), ls, decay[b]);
    end
    idle(2);

    // Consumer stalls across two completions: second result dropped, overrun sticks.
    doReset();
    ready_i = 1'b0;
    applyStimulus(16'h0100, 16'h0000, 4'd8, ev, lv, ls);
    checkOutput("stall_first_sample", ls, 16'h0100);
    checkOutput("stall_first_overrun", 16'(overrun_o), 16'h0000);
    applyStimulus(16'h0200, 16'h0000, 4'd8, ev, lv, ls);
    checkOutput("stall_held_sample", ls, 16'h0100);
    checkOutput("stall_held_valid", 16'(lv), 16'h0001);
    checkOutput("stall_overrun", 16'(overrun_o), 16'h0001);
    ready_i = 1'b1;
    tick();
    checkOutput("stall_accept_valid", 16'(valid_o), 16'h0000);
    checkOutput("stall_overrun_sticky", 16'(overrun_o), 16'h0001);
    doReset();
    checkOutput("overrun_cleared_by_reset", 16'(overrun_o), 16'h0000);

    // Acceptance in the very cycle a new result lands: new sample loaded, no overrun.
    ready_i = 1'b0;
    applyStimulus(16'h0100, 16'h0000, 4'd8, ev, lv, ls);
    checkOutput("swap_first_valid", 16'(lv), 16'h0001);
    runCes(16'h0300, 16'h0000, 4'd8);
    tick();
    ready_i = 1'b1;
    tick();
    checkOutput("swap_valid", 16'(valid_o), 16'h0001);
    checkOutput("swap_sample", sample_o, blk2Exp);
    checkOutput("swap_overrun", 16'(overrun_o), 16'h0000);
    tick();
    checkOutput("swap_drain_valid", 16'(valid_o), 16'h0000);

    // Reset after 7 of 16 samples: the partial block must not leak into the next output.
    doReset();
    ready_i  = 1'b1;
    volume_i = 4'd8;
    for (int i = 0; i < 7; i++) begin
      pushCe(16'h5000);
      idle(3);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
    sawValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pushCe(16'h0400);
      sawValid |= valid_o;
      if (i < 15) begin
        for (int j = 0; j < 3; j++) begin
          tick();
          sawValid |= valid_o;
        end
      end
    end
    tick();
    sawValid |= valid_o;
    checkOutput("midreset_no_early_output", 16'(sawValid), 16'h0000);
    tick();
    checkOutput("midreset_valid", 16'(valid_o), 16'h0001);
    checkOutput("midreset_sample", sample_o, 16'h0400);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
